// File: rtl/wb_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// wb_load_sequencer_if : decode/DRAM <-> write-back sequencer signal bundle
// Rev 1.0
// ============================================================================
interface wb_load_sequencer_if #(
   parameter int RD_W = 5
);
   logic            inst_valid;
   logic [1:0]      inst_wd_sel;
   logic            inst_rf_we;
   logic [RD_W-1:0] inst_rd;
   logic            dram_ack;
   logic            dram_req;
   logic            stall;
   logic [1:0]      wd_sel;
   logic            rf_we;
   logic [RD_W-1:0] wr_rd;
   logic            bus_err;

   modport master (
      output inst_valid, inst_wd_sel, inst_rf_we, inst_rd, dram_ack,
      input  dram_req, stall, wd_sel, rf_we, wr_rd, bus_err
   );

   modport slave (
      input  inst_valid, inst_wd_sel, inst_rf_we, inst_rd, dram_ack,
      output dram_req, stall, wd_sel, rf_we, wr_rd, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/wb_load_sequencer.sv
`default_nettype none
// ============================================================================
// wb_load_sequencer : register-file write-back control with load stall/timeout
// Rev 1.0
// ============================================================================
module wb_load_sequencer #(
   parameter int DRAM_TIMEOUT = 15,
   parameter int RD_W         = 5
) (
   input wire logic           clk,
   input wire logic           rst,
   wb_load_sequencer_if.slave bus_s
);
   localparam int               CNT_W      = $clog2(DRAM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DRAM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(DRAM_TIMEOUT);
   localparam logic [1:0]       C_SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LD_WAIT = 2'd1,
      S_LD_WB   = 2'd2,
      S_ERR     = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RD_W-1:0]  rd_q;
   logic             we_q;
   logic             dram_req_q;
   logic             bus_err_q;

   logic             w_is_load;
   logic             w_stall;
   logic             w_rf_we_raw;
   logic [1:0]       w_wd_sel;
   logic [RD_W-1:0]  w_wr_rd;

   // Load detection keys on the select alone; inst_rf_we only gates the final write.
   assign w_is_load = bus_s.inst_valid & (bus_s.inst_wd_sel == C_SEL_LOAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rd_q       <= '0;
         we_q       <= 1'b0;
         dram_req_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_is_load) begin
                  rd_q       <= bus_s.inst_rd;
                  we_q       <= bus_s.inst_rf_we;
                  cnt_q      <= '0;
                  dram_req_q <= 1'b1;
                  state_q    <= S_LD_WAIT;
               end
            end
            S_LD_WAIT: begin
               if (cnt_q != C_CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
               // An ack on the final allowed cycle still completes the load.
               if (bus_s.dram_ack) begin
                  dram_req_q <= 1'b0;
                  state_q    <= S_LD_WB;
               end else if (cnt_q >= C_CNT_LAST) begin
                  dram_req_q <= 1'b0;
                  bus_err_q  <= 1'b1;
                  state_q    <= S_ERR;
               end
            end
            S_LD_WB: begin
               dram_req_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            S_ERR: begin
               dram_req_q <= 1'b0;
               bus_err_q  <= 1'b1;
            end
            default: begin
               dram_req_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_stall     = 1'b0;
      w_rf_we_raw = 1'b0;
      w_wd_sel    = bus_s.inst_wd_sel;
      w_wr_rd     = bus_s.inst_rd;
      case (state_q)
         S_IDLE: begin
            w_stall     = w_is_load;
            w_rf_we_raw = bus_s.inst_valid & bus_s.inst_rf_we & ~w_is_load;
         end
         S_LD_WAIT: begin
            w_stall  = 1'b1;
            w_wd_sel = C_SEL_LOAD;
            w_wr_rd  = rd_q;
         end
         S_LD_WB: begin
            w_wd_sel    = C_SEL_LOAD;
            w_wr_rd     = rd_q;
            w_rf_we_raw = we_q;
         end
         S_ERR: begin
            w_stall  = 1'b1;
            w_wd_sel = C_SEL_LOAD;
            w_wr_rd  = rd_q;
         end
         default: begin
            w_stall = 1'b1;
         end
      endcase
   end

   // Register x0 is hardwired to zero, so never write it.
   assign bus_s.rf_we    = w_rf_we_raw & (w_wr_rd != '0);
   assign bus_s.stall    = w_stall;
   assign bus_s.wd_sel   = w_wd_sel;
   assign bus_s.wr_rd    = w_wr_rd;
   assign bus_s.dram_req = dram_req_q;
   assign bus_s.bus_err  = bus_err_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_load_sequencer.sv
`default_nettype none
// ============================================================================
// tb_wb_load_sequencer : scoreboard bench for the write-back load sequencer
// Rev 1.0
// ============================================================================
module tb_wb_load_sequencer;
   localparam int RD_W = 5;
   localparam int TMO  = 4;

   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic [1:0]      sel;
   } wb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   wb_t  exp_q[$];
   wb_t  mon_e;

   always #5 clk = ~clk;

   wb_load_sequencer_if #(.RD_W(RD_W)) bus ();

   wb_load_sequencer #(.DRAM_TIMEOUT(TMO), .RD_W(RD_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_s (bus)
   );

   // Scoreboard: every observed register-file write must match the oldest expected one.
   always @(negedge clk) begin
      if (bus.rf_we === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wb_spurious: write rd=%0d sel=%0d, required no write", bus.wr_rd, bus.wd_sel);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.wr_rd, bus.wd_sel} !== mon_e) begin
               bad++;
               $display("FAIL wb_data: got rd=%0d sel=%0d, required rd=%0d sel=%0d",
                        bus.wr_rd, bus.wd_sel, mon_e.rd, mon_e.sel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic we,
                        input logic [RD_W-1:0] rd, input logic ack);
      bus.inst_valid  = v;
      bus.inst_wd_sel = sel;
      bus.inst_rf_we  = we;
      bus.inst_rd     = rd;
      bus.dram_ack    = ack;
   endtask

   task automatic drain_check(input string name);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_missing_wb: pending=%0d, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Full load: issue cycle, ack_at LD_WAIT cycles, then one LD_WB cycle.
   task automatic do_load(input string name, input logic [RD_W-1:0] rd, input logic we, input int ack_at);
      drive(1'b1, 2'b11, we, rd, 1'b0);
      if (we && rd != '0) exp_q.push_back('{rd: rd, sel: 2'b11});
      @(negedge clk);
      total++;
      if ({bus.stall, bus.rf_we, bus.dram_req} !== 3'b100) begin
         bad++;
         $display("FAIL %s_issue: stall/we/req=%b, required 100", name, {bus.stall, bus.rf_we, bus.dram_req});
      end
      for (int i = 1; i <= ack_at; i++) begin
         tick();
         drive(1'b1, 2'b01, 1'b1, rd ^ 5'd1, (i == ack_at));
         @(negedge clk);
         total++;
         if ({bus.stall, bus.dram_req, bus.rf_we, bus.wd_sel, bus.wr_rd, bus.bus_err} !==
             {1'b1, 1'b1, 1'b0, 2'b11, rd, 1'b0}) begin
            bad++;
            $display("FAIL %s_wait%0d: stall=%b req=%b we=%b sel=%0d rd=%0d err=%b, required 1 1 0 3 %0d 0",
                     name, i, bus.stall, bus.dram_req, bus.rf_we, bus.wd_sel, bus.wr_rd, bus.bus_err, rd);
         end
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
      @(negedge clk);
      total++;
      if ({bus.stall, bus.dram_req, bus.wd_sel, bus.wr_rd, bus.rf_we, bus.bus_err} !==
          {1'b0, 1'b0, 2'b11, rd, (we && rd != '0), 1'b0}) begin
         bad++;
         $display("FAIL %s_wb: stall=%b req=%b sel=%0d rd=%0d we=%b err=%b, required 0 0 3 %0d %b 0",
                  name, bus.stall, bus.dram_req, bus.wd_sel, bus.wr_rd, bus.rf_we, bus.bus_err,
                  rd, (we && rd != '0));
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      total++;
      if ({bus.stall, bus.dram_req, bus.bus_err, bus.rf_we} !== 4'b0000) begin
         bad++;
         $display("FAIL reset: stall/req/err/we=%b, required 0000", {bus.stall, bus.dram_req, bus.bus_err, bus.rf_we});
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_alu();
      logic            vs  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0]      ss  [7] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
      logic            ws  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [RD_W-1:0] rs  [7] = '{5'd5, 5'd12, 5'd31, 5'd8, 5'd9, 5'd0, 5'd3};
      logic            as  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         logic exp_we;
         exp_we = vs[i] & ws[i] & (rs[i] != '0);
         drive(vs[i], ss[i], ws[i], rs[i], as[i]);
         if (exp_we) exp_q.push_back('{rd: rs[i], sel: ss[i]});
         @(negedge clk);
         total++;
         if ({bus.stall, bus.dram_req, bus.rf_we, bus.wd_sel, bus.wr_rd} !==
             {1'b0, 1'b0, exp_we, ss[i], rs[i]}) begin
            bad++;
            $display("FAIL alu%0d: stall=%b req=%b we=%b sel=%0d rd=%0d, required 0 0 %b %0d %0d",
                     i, bus.stall, bus.dram_req, bus.rf_we, bus.wd_sel, bus.wr_rd, exp_we, ss[i], rs[i]);
         end
         tick();
      end
      drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
      drain_check("alu");
   endtask

   task automatic test_load();
      do_load("load", 5'd7, 1'b1, 3);
      drain_check("load");
   endtask

   task automatic test_x0();
      do_load("x0ld", 5'd0, 1'b1, 2);
      do_load("nowe", 5'd14, 1'b0, 1);
      drain_check("x0");
   endtask

   task automatic test_timeout();
      drive(1'b1, 2'b11, 1'b1, 5'd9, 1'b0);
      tick();
      for (int i = 1; i <= TMO; i++) begin
         drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
         @(negedge clk);
         total++;
         if ({bus.dram_req, bus.stall, bus.bus_err} !== 3'b110) begin
            bad++;
            $display("FAIL tmo_wait%0d: req/stall/err=%b, required 110", i, {bus.dram_req, bus.stall, bus.bus_err});
         end
         tick();
      end
      for (int i = 0; i < 22; i++) begin
         drive(1'b1, 2'b01, 1'b1, 5'd3, i[0]);
         @(negedge clk);
         total++;
         if ({bus.bus_err, bus.dram_req, bus.stall, bus.rf_we} !== 4'b1010) begin
            bad++;
            $display("FAIL tmo_err%0d: err/req/stall/we=%b, required 1010", i,
                     {bus.bus_err, bus.dram_req, bus.stall, bus.rf_we});
         end
         tick();
      end
      rst = 1'b1;
      drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.bus_err, bus.stall, bus.dram_req} !== 3'b000) begin
         bad++;
         $display("FAIL tmo_clear: err/stall/req=%b, required 000", {bus.bus_err, bus.stall, bus.dram_req});
      end
      tick();
      drain_check("tmo");
   endtask

   task automatic test_reset_in_wait();
      drive(1'b1, 2'b11, 1'b1, 5'd11, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b1, 2'b01, 1'b1, 5'd6, 1'b0);
      @(negedge clk);
      total++;
      if ({bus.dram_req, bus.stall, bus.rf_we} !== 3'b110) begin
         bad++;
         $display("FAIL rstw_wait: req/stall/we=%b, required 110", {bus.dram_req, bus.stall, bus.rf_we});
      end
      tick();
      rst = 1'b0;
      exp_q.push_back('{rd: 5'd6, sel: 2'b01});
      @(negedge clk);
      total++;
      if ({bus.dram_req, bus.stall, bus.rf_we, bus.wr_rd} !== {1'b0, 1'b0, 1'b1, 5'd6}) begin
         bad++;
         $display("FAIL rstw_idle: req=%b stall=%b we=%b rd=%0d, required 0 0 1 6",
                  bus.dram_req, bus.stall, bus.rf_we, bus.wr_rd);
      end
      tick();
      drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
      drain_check("rstw");
   endtask

   task automatic test_boundary();
      do_load("edge", 5'd20, 1'b1, TMO);
      total++;
      if (bus.bus_err !== 1'b0) begin
         bad++;
         $display("FAIL edge_err: bus_err=%b, required 0", bus.bus_err);
      end
      drain_check("edge");
   endtask

   task automatic test_back_to_back();
      do_load("b2b_a", 5'd1, 1'b1, 1);
      do_load("b2b_b", 5'd2, 1'b1, 2);
      do_load("b2b_c", 5'd30, 1'b1, 4);
      drain_check("b2b");
   endtask

   initial begin
      drive(1'b0, 2'b00, 1'b0, '0, 1'b0);
      test_reset();
      test_alu();
      test_load();
      test_x0();
      test_timeout();
      test_reset_in_wait();
      test_boundary();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
